// File: rtl/mdr_cmd_sequencer.sv
// mdr_cmd_sequencer
// Initiator-side controller for the multiply/divide/root (MDR) handshake.
// It takes one request (op, X, Y), starts the MDR, feeds operands when the
// MDR prompts for them, waits for completion, then presents result,
// remainder and error on a valid/ready response port. Only one operation
// is in flight at a time.
//
// Optional build macro: MDR_SEQ_TIMEOUT_EN enables a watchdog that ends a
// stalled operation after TIMEOUT_CYCLES wait cycles with rsp_timeout=1.
// Without it rsp_timeout is tied low and the sequencer waits indefinitely.
//
// Ports
//   clk, rst         clock (rising edge), synchronous active-high reset
//   req_*            request port: valid/ready, op (00 MUL, 01 DIV,
//                    10 SQRT, 11 reserved), operands x and y
//   rsp_*            response port: valid/ready, result, remainder,
//                    error, timeout
//   mdr_op/data      op code and operand bus towards the MDR
//   mdr_start/load   one-cycle start pulse / operand strobe
//   mdr_load_x/y     MDR prompts for operand X / Y
//   mdr_error/ready  MDR error flag / idle-done level
//   mdr_result/remainder  MDR outputs, captured on completion
module mdr_cmd_sequencer #(
    parameter int DW             = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [DW-1:0] req_x,
    input  logic [DW-1:0] req_y,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_result,
    output logic [DW-1:0] rsp_remainder,
    output logic          rsp_error,
    output logic          rsp_timeout,
    output logic [1:0]    mdr_op,
    output logic [DW-1:0] mdr_data,
    output logic          mdr_start,
    output logic          mdr_load,
    input  logic          mdr_load_x,
    input  logic          mdr_load_y,
    input  logic          mdr_error,
    input  logic          mdr_ready,
    input  logic [DW-1:0] mdr_result,
    input  logic [DW-1:0] mdr_remainder
);

    localparam logic [1:0] OP_SQRT = 2'b10;
    localparam logic [1:0] OP_RSV  = 2'b11;

    typedef enum logic [2:0] {
        IDLE, START, WAIT_X, LOAD_X, WAIT_Y, LOAD_Y, WAIT_DONE, RESP
    } state_t;

    state_t        state, state_n;
    logic [1:0]    op_q;
    logic [DW-1:0] x_q, y_q;
    logic          err_sticky;
    logic          busy_seen;
    logic          accept;
    logic          in_wait;
    logic          done_hit;
    logic          tmo_hit;

    assign accept   = (state == IDLE) && req_valid && req_ready;
    assign in_wait  = (state == WAIT_X) || (state == WAIT_Y) || (state == WAIT_DONE);
    // A ready level is only trusted once the MDR has been seen busy, so a
    // stale ready right after start never counts as completion. Completion
    // seen while still waiting for an operand means the MDR aborted.
    assign done_hit = in_wait && busy_seen && mdr_ready;

`ifdef MDR_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wd_cnt;

    assign tmo_hit = in_wait && !done_hit && (wd_cnt >= CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || state == START) begin
            wd_cnt <= '0;
        end else if (in_wait) begin
            wd_cnt <= wd_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_timeout <= 1'b0;
        end else if (accept || done_hit) begin
            rsp_timeout <= 1'b0;
        end else if (tmo_hit) begin
            rsp_timeout <= 1'b1;
        end
    end
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
    assign tmo_hit        = 1'b0;
    assign rsp_timeout    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = (req_op == OP_RSV) ? RESP : START;
                end
            end
            START: state_n = WAIT_X;
            WAIT_X: begin
                if (done_hit || tmo_hit) begin
                    state_n = RESP;
                end else if (mdr_load_x) begin
                    state_n = LOAD_X;
                end
            end
            LOAD_X: state_n = (op_q == OP_SQRT) ? WAIT_DONE : WAIT_Y;
            WAIT_Y: begin
                if (done_hit || tmo_hit) begin
                    state_n = RESP;
                end else if (mdr_load_y) begin
                    state_n = LOAD_Y;
                end
            end
            LOAD_Y: state_n = WAIT_DONE;
            WAIT_DONE: begin
                if (done_hit || tmo_hit) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Operand latches carry no reset; they are only read after an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= req_op;
            x_q  <= req_x;
            y_q  <= req_y;
        end
    end

    // Outputs are registered from the next state so each strobe lines up
    // with the cycle spent in its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_result    <= '0;
            rsp_remainder <= '0;
            rsp_error     <= 1'b0;
            mdr_op        <= '0;
            mdr_data      <= '0;
            mdr_start     <= 1'b0;
            mdr_load      <= 1'b0;
            err_sticky    <= 1'b0;
            busy_seen     <= 1'b0;
        end else begin
            req_ready <= (state_n == IDLE) && mdr_ready;
            rsp_valid <= (state_n == RESP);
            mdr_start <= (state_n == START);
            mdr_load  <= (state_n == LOAD_X) || (state_n == LOAD_Y);

            if (state_n == LOAD_X) begin
                mdr_data <= x_q;
            end else if (state_n == LOAD_Y) begin
                mdr_data <= y_q;
            end

            if (accept) begin
                err_sticky <= 1'b0;
                busy_seen  <= 1'b0;
                if (req_op != OP_RSV) begin
                    mdr_op <= req_op;
                end
            end else begin
                if (state != IDLE && state != RESP) begin
                    err_sticky <= err_sticky | mdr_error;
                end
                if (state != IDLE && state != START && state != RESP && !mdr_ready) begin
                    busy_seen <= 1'b1;
                end
            end

            if (accept && req_op == OP_RSV) begin
                rsp_result    <= '0;
                rsp_remainder <= '0;
                rsp_error     <= 1'b1;
            end else if (done_hit) begin
                rsp_result    <= mdr_result;
                rsp_remainder <= mdr_remainder;
                rsp_error     <= err_sticky | mdr_error;
            end else if (tmo_hit) begin
                rsp_result    <= '0;
                rsp_remainder <= '0;
                rsp_error     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mdr_cmd_sequencer.sv
// Testbench for mdr_cmd_sequencer: a behavioural MDR responder, a request
// driver and a reference model computing expected responses from the
// request alone.
module tb_mdr_cmd_sequencer;

    localparam int DW  = 16;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready;
    logic [1:0]    req_op;
    logic [DW-1:0] req_x, req_y;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_result, rsp_remainder;
    logic          rsp_error, rsp_timeout;
    logic [1:0]    mdr_op;
    logic [DW-1:0] mdr_data;
    logic          mdr_start, mdr_load;
    logic          mdr_load_x, mdr_load_y, mdr_error, mdr_ready;
    logic [DW-1:0] mdr_result, mdr_remainder;

    always #5 clk = ~clk;

    mdr_cmd_sequencer #(.DW(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_x(req_x), .req_y(req_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_remainder(rsp_remainder), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .mdr_op(mdr_op), .mdr_data(mdr_data), .mdr_start(mdr_start), .mdr_load(mdr_load),
        .mdr_load_x(mdr_load_x), .mdr_load_y(mdr_load_y), .mdr_error(mdr_error),
        .mdr_ready(mdr_ready), .mdr_result(mdr_result), .mdr_remainder(mdr_remainder)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Arithmetic the MDR performs: MUL gives low/high product halves, DIV
    // gives quotient/remainder (all-ones and X with error on divide by 0),
    // SQRT gives floor root and X - root^2, reserved gives error only.
    function automatic void mdr_math(input logic [1:0] op, input logic [DW-1:0] x,
                                     input logic [DW-1:0] y, output logic [DW-1:0] r,
                                     output logic [DW-1:0] rem, output logic err);
        logic [2*DW-1:0] p;
        int s;
        r = '0; rem = '0; err = 1'b0;
        case (op)
            2'b00: begin
                p = (2*DW)'(x) * (2*DW)'(y);
                r = p[DW-1:0];
                rem = p[2*DW-1:DW];
            end
            2'b01: begin
                if (y == '0) begin
                    r = '1; rem = x; err = 1'b1;
                end else begin
                    r = x / y; rem = x % y;
                end
            end
            2'b10: begin
                s = 0;
                while ((s + 1) * (s + 1) <= int'(x)) s++;
                r = DW'(s);
                rem = x - DW'(s * s);
            end
            default: err = 1'b1;
        endcase
    endfunction

    // Behavioural MDR: prompts for operands after random delays, computes
    // from what was actually loaded, optionally pulses error before done and
    // emits stray load prompts while computing.
    int            ph, cnt, y_delay;
    bit            hang, err_inject, spur_en;
    logic [1:0]    m_op;
    logic [DW-1:0] m_x, m_y, m_r, m_rem;
    logic          m_err;

    initial begin
        ph = 0; cnt = 0; y_delay = 0; hang = 0; err_inject = 0; spur_en = 0;
        m_op = '0; m_x = '0; m_y = '0; m_r = '0; m_rem = '0; m_err = 1'b0;
        mdr_ready = 1'b1; mdr_load_x = 1'b0; mdr_load_y = 1'b0; mdr_error = 1'b0;
        mdr_result = '0; mdr_remainder = '0;
        forever begin
            @(negedge clk);
            mdr_load_x = 1'b0;
            mdr_load_y = 1'b0;
            mdr_error  = 1'b0;
            if (rst) begin
                ph = 0;
                mdr_ready = 1'b1;
            end else begin
                case (ph)
                    0: if (mdr_start) begin
                        m_op = mdr_op; m_y = '0;
                        mdr_ready = 1'b0;
                        mdr_result = DW'($urandom);
                        mdr_remainder = DW'($urandom);
                        cnt = $urandom_range(0, 3);
                        ph = 1;
                    end
                    1: if (!hang) begin
                        if (cnt == 0) begin
                            mdr_load_x = 1'b1; ph = 2;
                        end else cnt--;
                    end
                    2: if (mdr_load) begin
                        m_x = mdr_data;
                        if (m_op == 2'b10) begin
                            ph = 5; cnt = $urandom_range(3, 7);
                            mdr_math(m_op, m_x, m_y, m_r, m_rem, m_err);
                        end else begin
                            ph = 3; cnt = $urandom_range(0, 3) + y_delay;
                        end
                    end
                    3: if (cnt == 0) begin
                        mdr_load_y = 1'b1; ph = 4;
                    end else cnt--;
                    4: if (mdr_load) begin
                        m_y = mdr_data;
                        ph = 5; cnt = $urandom_range(3, 7);
                        mdr_math(m_op, m_x, m_y, m_r, m_rem, m_err);
                    end
                    default: begin
                        if (cnt == 2 && spur_en) begin
                            mdr_load_x = 1'b1; mdr_load_y = 1'b1;
                        end
                        if (cnt == 1 && (m_err || err_inject)) mdr_error = 1'b1;
                        if (cnt == 0) begin
                            mdr_result = m_r; mdr_remainder = m_rem;
                            mdr_ready = 1'b1; ph = 0;
                        end else cnt--;
                    end
                endcase
            end
        end
    end

    int            n_start, n_load;
    logic [DW-1:0] load_q[$];

    initial begin
        n_start = 0; n_load = 0;
        forever begin
            @(negedge clk);
            if (mdr_start) n_start++;
            if (mdr_load) begin
                n_load++;
                load_q.push_back(mdr_data);
            end
        end
    end

    task automatic send_req(input logic [1:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y);
        int k;
        k = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_x = x; req_y = y;
        while (!req_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("accept_wait", 64'(k >= 100), 64'(0));
        @(negedge clk);
        req_valid = 1'b0;
        req_op = 2'($urandom); req_x = DW'($urandom); req_y = DW'($urandom);
    endtask

    task automatic get_rsp(input string tag, input logic [DW-1:0] er, input logic [DW-1:0] erem,
                           input logic eerr, input logic etmo, input int hold, output int waited);
        int k;
        k = 0;
        while (!rsp_valid && k < 300) begin
            @(negedge clk);
            k++;
        end
        waited = k;
        chk({tag, "_valid"}, 64'(rsp_valid), 64'(1));
        chk({tag, "_result"}, 64'(rsp_result), 64'(er));
        chk({tag, "_remainder"}, 64'(rsp_remainder), 64'(erem));
        chk({tag, "_error"}, 64'(rsp_error), 64'(eerr));
        chk({tag, "_timeout"}, 64'(rsp_timeout), 64'(etmo));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold"}, 64'({rsp_valid, rsp_result, rsp_remainder, rsp_error, req_ready}),
                64'({1'b1, er, erem, eerr, 1'b0}));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_released"}, 64'(rsp_valid), 64'(0));
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic [DW-1:0] x,
                         input logic [DW-1:0] y, input bit inject, input bit spur, input int hold);
        logic [DW-1:0] er, erem;
        logic          eerr;
        int            w;
        n_start = 0; n_load = 0; load_q.delete();
        err_inject = inject; spur_en = spur;
        mdr_math(op, x, y, er, erem, eerr);
        if (op != 2'b11) eerr = eerr | inject;
        send_req(op, x, y);
        get_rsp(tag, er, erem, eerr, 1'b0, hold, w);
        if (op == 2'b11) chk({tag, "_rsv_latency"}, 64'(w), 64'(0));
        chk({tag, "_starts"}, 64'(n_start), 64'((op == 2'b11) ? 0 : 1));
        chk({tag, "_loads"}, 64'(n_load), 64'((op == 2'b11) ? 0 : (op == 2'b10) ? 1 : 2));
        if (load_q.size() >= 1) chk({tag, "_data_x"}, 64'(load_q[0]), 64'(x));
        if (load_q.size() >= 2) chk({tag, "_data_y"}, 64'(load_q[1]), 64'(y));
    endtask

    task automatic all_outputs_zero(input string tag);
        chk(tag, 64'({req_ready, rsp_valid, rsp_result, rsp_remainder, rsp_error, rsp_timeout,
                      mdr_op, mdr_data, mdr_start, mdr_load}), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        bit  seen;
        int  w;
        logic [1:0]    op;
        logic [DW-1:0] x, y;

        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_x = '0; req_y = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        all_outputs_zero("reset_outputs");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_req_ready", 64'(req_ready), 64'(1));

        do_op("mul_7x6", 2'b00, 16'd7, 16'd6, 1'b0, 1'b0, 0);
        do_op("div_17_5", 2'b01, 16'd17, 16'd5, 1'b0, 1'b0, 0);
        do_op("div_17_0", 2'b01, 16'd17, 16'd0, 1'b0, 1'b0, 1);
        do_op("sqrt_81", 2'b10, 16'd81, 16'd1234, 1'b0, 1'b1, 0);
        do_op("rsv_op", 2'b11, 16'd55, 16'd66, 1'b0, 1'b0, 5);
        do_op("mul_err_pulse", 2'b00, 16'd300, 16'd500, 1'b1, 1'b1, 2);

        // Reset while the sequencer waits for the Y prompt.
        n_load = 0; y_delay = 20;
        send_req(2'b00, 16'd100, 16'd200);
        k = 0;
        while (n_load < 1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("wait_y_reach", 64'(k >= 50), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        all_outputs_zero("mid_reset_outputs");
        @(negedge clk);
        rst = 1'b0;
        y_delay = 0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        chk("mid_reset_no_rsp", 64'(seen), 64'(0));
        do_op("mul_3x4", 2'b00, 16'd3, 16'd4, 1'b0, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            x  = DW'($urandom);
            y  = ($urandom_range(0, 5) == 0) ? '0 :
                 ($urandom_range(0, 1) == 1) ? DW'($urandom_range(1, 300)) : DW'($urandom);
            do_op("rand", op, x, y, ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3));
        end

        // MDR that never prompts for X.
        hang = 1;
        n_start = 0;
        send_req(2'b00, 16'd5, 16'd5);
`ifdef MDR_SEQ_TIMEOUT_EN
        get_rsp("timeout", '0, '0, 1'b1, 1'b1, 0, w);
        chk("timeout_latency_ok", 64'(w <= TMO + 2), 64'(1));
`else
        seen = 0;
        repeat (2000) begin
            @(negedge clk);
            if (rsp_valid || rsp_timeout) seen = 1;
        end
        chk("no_timeout_wait", 64'(seen), 64'(0));
        w = 0;
`endif
        chk("hang_starts", 64'(n_start), 64'(1));
        @(negedge clk);
        rst = 1'b1;
        hang = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        do_op("after_hang", 2'b01, 16'd1000, 16'd7, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mdr_cmd_sequencer.md
Name: mdr_cmd_sequencer

Overview:
Initiator-side controller for the multiply/divide/root (MDR) handshake. It accepts one operation request (op, X, Y) on a valid/ready port and drives the MDR start/load/data/op signals. It follows the MDR's load_x/load_y prompts, waits for completion, then returns result, remainder and error on a valid/ready response port. It sits between a command source (CPU-side register block or test sequencer) and the MDR datapath.

Parameters:
DW, 16, data width of data/result/remainder (matches data_t).
TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only with MDR_SEQ_TIMEOUT_EN.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid&&req_ready
req_op  in  2  00 MUL, 01 DIV, 10 SQRT, 11 reserved
req_x  in  DW  operand X
req_y  in  DW  operand Y (ignored for SQRT)
rsp_valid  out  1  response valid, held until rsp_ready
rsp_ready  in  1  response consumed
rsp_result  out  DW  captured result
rsp_remainder  out  DW  captured remainder
rsp_error  out  1  MDR error seen, or reserved op
rsp_timeout  out  1  watchdog expiry (constant 0 without macro)
mdr_op  out  2  op to MDR
mdr_data  out  DW  operand bus to MDR
mdr_start  out  1  one-cycle start pulse
mdr_load  out  1  one-cycle operand strobe
mdr_load_x  in  1  MDR requests X
mdr_load_y  in  1  MDR requests Y
mdr_error  in  1  MDR error flag
mdr_ready  in  1  MDR idle/done level
mdr_result  in  DW  MDR result
mdr_remainder  in  DW  MDR remainder

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high.
- All outputs are registered.
- Reset:
  - State goes to IDLE.
  - All outputs go to 0 on the next edge.
  - An in-flight operation is abandoned and no response is produced.
- FSM states: IDLE, START, WAIT_X, LOAD_X, WAIT_Y, LOAD_Y, WAIT_DONE, RESP.
- IDLE:
  - req_ready = mdr_ready.
  - On accept, latch op/x/y and clear err_sticky and busy_seen.
  - Valid op goes to START.
  - Op 11 goes directly to RESP with result=0, remainder=0, rsp_error=1; the MDR is not touched.
- START:
  - mdr_start=1 and mdr_op=op for exactly one cycle, then WAIT_X.
  - mdr_op holds the latched op until the next accept.
- WAIT_X: on mdr_load_x=1, go to LOAD_X.
- LOAD_X:
  - mdr_data=X and mdr_load=1 for one cycle.
  - Next state is WAIT_DONE for SQRT, else WAIT_Y.
- WAIT_Y / LOAD_Y: same as WAIT_X / LOAD_X using mdr_load_y and Y, then WAIT_DONE.
- mdr_data holds its last driven value outside load cycles.
- busy_seen:
  - Set on any cycle after START where mdr_ready=0.
  - Completion requires busy_seen=1 && mdr_ready=1.
  - This means a stale ready level right after start is never taken as done.
- Completion:
  - Checked in WAIT_X, WAIT_Y and WAIT_DONE; early completion means the MDR aborted.
  - On completion, capture mdr_result, mdr_remainder and err_sticky|mdr_error, then go to RESP.
- err_sticky: OR of mdr_error sampled every cycle from START through completion.
- Ignored inputs: load_x/load_y pulses arriving outside the matching WAIT state.
- RESP:
  - rsp_valid=1 with payload stable until rsp_ready=1.
  - Then clear rsp_valid and go to IDLE.
  - rsp_valid and rsp_ready high in the same cycle as a new req_valid: the request is not accepted until the following cycle (req_ready=0 in RESP).
- Throughput: at most one operation in flight. Minimum latency from accept to rsp_valid is MDR compute time + 4 cycles for MUL/DIV, +3 for SQRT.

Optional Feature:
MDR_SEQ_TIMEOUT_EN:
- Defined:
  - A cycle counter clears at START and increments in WAIT_X, WAIT_Y and WAIT_DONE.
  - Reaching TIMEOUT_CYCLES goes to RESP with rsp_timeout=1, rsp_error=1, result=0, remainder=0.
  - Reset of the MDR is the system's responsibility.
- Undefined: no counter; rsp_timeout is tied to 0; the sequencer waits indefinitely.

Test Plan:
- MUL, X=7, Y=6; model MDR asserts load_x, load_y, drops ready, returns 42 -> one mdr_start pulse, mdr_load with data 7 then 6, rsp_result=42, rsp_remainder=0, rsp_error=0.
- DIV, X=17, Y=5 -> rsp_result=3, rsp_remainder=2. Repeat with Y=0 and model pulsing mdr_error before ready -> rsp_error=1.
- SQRT, X=81 -> exactly one mdr_load (data 81), no Y phase, rsp_result=9.
- Reserved op 11 -> no mdr_start; rsp_valid one cycle after accept with rsp_error=1, result 0. Hold rsp_ready=0 for 5 cycles -> payload stable, req_ready=0 throughout.
- rst asserted while in WAIT_Y -> next cycle all outputs 0, state IDLE, no rsp_valid. A subsequent MUL 3x4 returns 12.
- With MDR_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, model never asserts load_x -> rsp_timeout=1, rsp_error=1 within 16+2 cycles of start. Without macro -> rsp_valid stays 0 for 2000 cycles.
